// File: rtl/cc_apb_arb.sv
// cc_apb_arb: round-robin two-requester arbiter driving single APB3 transfers with wait-state timeout
module cc_apb_arb #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid_i,
   input  logic [11:0] req0_addr_i,
   input  logic        req0_write_i,
   input  logic [31:0] req0_wdata_i,
   output logic        req0_ready_o,
   input  logic        req1_valid_i,
   input  logic [11:0] req1_addr_i,
   input  logic        req1_write_i,
   input  logic [31:0] req1_wdata_i,
   output logic        req1_ready_o,
   output logic        resp0_valid_o,
   output logic [31:0] resp0_rdata_o,
   output logic        resp0_err_o,
   output logic        resp1_valid_o,
   output logic [31:0] resp1_rdata_o,
   output logic        resp1_err_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [11:0] paddr_o,
   output logic [31:0] pwdata_o,
   input  logic        pready_i,
   input  logic        pslverr_i,
   input  logic [31:0] prdata_i
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t state;
   logic rr, owner, gnt1, tout;
   logic [7:0] cnt;
   logic [31:0] rdata;
   logic err;
   assign gnt1 = req1_valid_i & (~req0_valid_i | rr);
   assign req0_ready_o = (state == IDLE) & req0_valid_i & ~gnt1;
   assign req1_ready_o = (state == IDLE) & gnt1;
   assign tout = cnt == 8'(TIMEOUT - 1);
   assign rdata = pready_i & ~pwrite_o ? prdata_i : '0;
   assign err = pready_i ? pslverr_i : 1'b1;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr <= 1'b0;
         owner <= 1'b0;
         cnt <= '0;
         psel_o <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o <= 1'b0;
         paddr_o <= '0;
         pwdata_o <= '0;
         resp0_valid_o <= 1'b0;
         resp1_valid_o <= 1'b0;
         resp0_rdata_o <= '0;
         resp1_rdata_o <= '0;
         resp0_err_o <= 1'b0;
         resp1_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0_valid_i | req1_valid_i) begin
               owner <= gnt1;
               rr <= ~gnt1;
               paddr_o <= gnt1 ? req1_addr_i : req0_addr_i;
               pwdata_o <= gnt1 ? req1_wdata_i : req0_wdata_i;
               pwrite_o <= gnt1 ? req1_write_i : req0_write_i;
               psel_o <= 1'b1;
               state <= SETUP;
            end
            SETUP: begin
               penable_o <= 1'b1;
               cnt <= '0;
               state <= ACCESS;
            end
            ACCESS: if (pready_i | tout) begin
               psel_o <= 1'b0;
               penable_o <= 1'b0;
               pwrite_o <= 1'b0;
               resp0_valid_o <= ~owner;
               resp1_valid_o <= owner;
               // only the owner's response registers change; the other port keeps its last result
               if (owner) begin
                  resp1_rdata_o <= rdata;
                  resp1_err_o <= err;
               end else begin
                  resp0_rdata_o <= rdata;
                  resp0_err_o <= err;
               end
               state <= RESP;
            end else begin
               cnt <= cnt + 8'd1;
            end
            RESP: begin
               resp0_valid_o <= 1'b0;
               resp1_valid_o <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cc_apb_arb.sv
// tb_cc_apb_arb: directed bench with response scoreboard for cc_apb_arb
module tb_cc_apb_arb;
   logic clk, rst;
   logic req0_valid_i, req0_write_i, req0_ready_o;
   logic req1_valid_i, req1_write_i, req1_ready_o;
   logic [11:0] req0_addr_i, req1_addr_i, paddr_o;
   logic [31:0] req0_wdata_i, req1_wdata_i, pwdata_o, prdata_i, prd;
   logic resp0_valid_o, resp0_err_o, resp1_valid_o, resp1_err_o;
   logic [31:0] resp0_rdata_o, resp1_rdata_o;
   logic psel_o, penable_o, pwrite_o, pready_i, pslverr_i, auto_rd;
   typedef struct {logic port; logic [31:0] rdata; logic err;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0;
   int errors = 0;
   cc_apb_arb #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_write_i(req0_write_i),
      .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_write_i(req1_write_i),
      .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o),
      .resp0_valid_o(resp0_valid_o), .resp0_rdata_o(resp0_rdata_o), .resp0_err_o(resp0_err_o),
      .resp1_valid_o(resp1_valid_o), .resp1_rdata_o(resp1_rdata_o), .resp1_err_o(resp1_err_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
      .pwdata_o(pwdata_o), .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
   );
   // auto mode lets back-to-back reads return an address-derived value
   assign prdata_i = auto_rd ? 32'h1000 + {20'h0, paddr_o} : prd;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic p, input logic [31:0] d, input logic er);
      sb.push_back('{port: p, rdata: d, err: er});
   endtask
   task automatic nc;
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b1; auto_rd = 1'b0; prd = '0; pready_i = 1'b0; pslverr_i = 1'b0;
      req0_valid_i = 1'b0; req0_addr_i = '0; req0_write_i = 1'b0; req0_wdata_i = '0;
      req1_valid_i = 1'b0; req1_addr_i = '0; req1_write_i = 1'b0; req1_wdata_i = '0;
      fork
         forever begin
            @(negedge clk);
            if (resp0_valid_o || resp1_valid_o) begin
               chk("resp_expected", {30'h0, resp0_valid_o && resp1_valid_o, sb.size() == 0}, 32'h0);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("resp_port", {31'h0, resp1_valid_o}, {31'h0, e.port});
                  chk("resp_rdata", resp1_valid_o ? resp1_rdata_o : resp0_rdata_o, e.rdata);
                  chk("resp_err", {31'h0, resp1_valid_o ? resp1_err_o : resp0_err_o}, {31'h0, e.err});
               end
            end
         end
      join_none
      repeat (2) nc;
      #1 chk("rst_ctl", {psel_o, penable_o, pwrite_o, resp0_valid_o, resp1_valid_o, resp0_err_o, resp1_err_o}, 0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_pwdata", pwdata_o, 0);
      chk("rst_rdata", resp0_rdata_o | resp1_rdata_o, 0);
      rst = 1'b0;
      // single read, zero wait
      nc; req0_valid_i = 1'b1; req0_addr_i = 12'h000; pready_i = 1'b1; prd = 32'h0001_0101;
      #1 chk("rd_ready", {req0_ready_o, req1_ready_o}, 2'b10);
      push(1'b0, 32'h0001_0101, 1'b0);
      nc; req0_valid_i = 1'b0;
      #1 chk("rd_setup", {psel_o, penable_o, pwrite_o}, 3'b100);
      chk("rd_paddr", paddr_o, 12'h000);
      nc; #1 chk("rd_access", {psel_o, penable_o}, 2'b11);
      nc; #1 chk("rd_resp", {resp0_valid_o, resp1_valid_o, psel_o}, 3'b100);
      // write with 2 wait states
      nc; req1_valid_i = 1'b1; req1_addr_i = 12'h004; req1_write_i = 1'b1; req1_wdata_i = 32'hDEAD_BEEF;
      pready_i = 1'b0; prd = 32'hFFFF_FFFF;
      #1 chk("wr_ready", {req0_ready_o, req1_ready_o}, 2'b01);
      push(1'b1, 32'h0, 1'b0);
      nc; req1_valid_i = 1'b0; req1_wdata_i = 32'h0;
      #1 chk("wr_setup", {psel_o, penable_o, pwrite_o}, 3'b101);
      chk("wr_paddr", paddr_o, 12'h004);
      for (int i = 0; i < 3; i++) begin
         nc; pready_i = (i == 2);
         #1 chk("wr_access", {psel_o, penable_o, pwrite_o, resp1_valid_o}, 4'b1110);
         chk("wr_pwdata", pwdata_o, 32'hDEAD_BEEF);
      end
      nc; pready_i = 1'b0;
      #1 chk("wr_resp", {resp0_valid_o, resp1_valid_o, psel_o, pwrite_o}, 4'b0100);
      req1_write_i = 1'b0;
      // contention right after reset: strict alternation starting with port 0
      nc; rst = 1'b1;
      nc; rst = 1'b0; auto_rd = 1'b1; pready_i = 1'b1;
      req0_valid_i = 1'b1; req1_valid_i = 1'b1; req0_addr_i = 12'h010; req1_addr_i = 12'h020;
      for (int i = 0; i < 4; i++) begin
         #1 chk("cont_grant", {req0_ready_o, req1_ready_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
         push(1'(i % 2), (i % 2 == 0) ? 32'h1010 : 32'h1020, 1'b0);
         repeat (4) nc;
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; auto_rd = 1'b0;
      // slave error
      nc; req0_valid_i = 1'b1; req0_addr_i = 12'h008; pslverr_i = 1'b1; prd = 32'h0000_1234; pready_i = 1'b1;
      #1 chk("err_ready", {req0_ready_o, req1_ready_o}, 2'b10);
      push(1'b0, 32'h0000_1234, 1'b1);
      nc; req0_valid_i = 1'b0;
      repeat (2) nc;
      #1 chk("err_resp", {resp0_valid_o, resp1_valid_o}, 2'b10);
      pslverr_i = 1'b0;
      // timeout with pready held low
      nc; req0_valid_i = 1'b1; req0_addr_i = 12'h00C; pready_i = 1'b0; prd = 32'h0000_ABCD;
      #1 chk("to_ready", {req0_ready_o, req1_ready_o}, 2'b10);
      push(1'b0, 32'h0, 1'b1);
      nc; req0_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nc; #1 chk("to_access", {psel_o, penable_o, resp0_valid_o}, 3'b110);
      end
      nc; #1 chk("to_resp", {resp0_valid_o, psel_o, penable_o}, 3'b100);
      // reset during ACCESS abandons the transfer and clears rr
      nc; req0_valid_i = 1'b1; req0_addr_i = 12'h010;
      #1 chk("rm_ready", {req0_ready_o, req1_ready_o}, 2'b10);
      nc; req0_valid_i = 1'b0;
      nc; #1 chk("rm_access", {psel_o, penable_o}, 2'b11);
      rst = 1'b1;
      nc; #1 chk("rm_apb", {psel_o, penable_o, resp0_valid_o, resp1_valid_o}, 4'b0000);
      rst = 1'b0; req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      #1 chk("rm_rr", {req0_ready_o, req1_ready_o}, 2'b10);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      repeat (6) nc;
      #1 chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cc_apb_arb.md
# cc_apb_arb

Two-requester arbiter and APB master sequencer for the cache-controller configuration bus. It accepts single register read/write requests from two independent requesters (port 0: host CSR path, port 1: debug path), arbitrates them round-robin, and drives one APB3 transfer at a time onto the shared config slave. It returns read data and error status to the originating requester, and bounds every transfer with a wait-state timeout.

## Interface
- TIMEOUT, default 16: maximum ACCESS-phase cycles with `pready_i` low before forced termination; legal range 1..255.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid_i / req1_valid_i  in  1  request pending; held until accepted.
- req0_addr_i / req1_addr_i  in  12  register byte address.
- req0_write_i / req1_write_i  in  1  1 = write, 0 = read.
- req0_wdata_i / req1_wdata_i  in  32  write data.
- req0_ready_o / req1_ready_o  out  1  accept strobe; request captured this cycle.
- resp0_valid_o / resp1_valid_o  out  1  one-cycle completion strobe.
- resp0_rdata_o / resp1_rdata_o  out  32  read data; 0 for writes and timeouts.
- resp0_err_o / resp1_err_o  out  1  `pslverr_i` captured, or timeout.
- psel_o, penable_o, pwrite_o  out  1  APB controls.
- paddr_o  out  12  APB address.
- pwdata_o  out  32  APB write data.
- pready_i, pslverr_i  in  1  APB slave status.
- prdata_i  in  32  APB read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `reqN_valid_i`, select a winner. If both are valid, the requester named by priority pointer `rr` wins; otherwise the single valid requester wins. `reqN_ready_o` is asserted combinationally for the winner only, and only in IDLE.
- On the accepting edge, capture addr, write and wdata into holding registers and record the owner. Set `rr` to the non-winner, then go to SETUP.
- SETUP (1 cycle): `psel_o`=1, `penable_o`=0, APB address/data/write driven from the holding registers. Next state is ACCESS.
- ACCESS: `psel_o`=1, `penable_o`=1. Timeout counter starts at 0 and increments each ACCESS cycle with `pready_i`=0.
  - `pready_i`=1: capture `prdata_i` (reads only; writes capture 0) and `pslverr_i`, then go to RESP.
  - Counter reaches TIMEOUT-1 with `pready_i` still low: capture rdata=0 and err=1, then go to RESP.
- RESP (1 cycle): `respN_valid_o`=1 for the owner only. `respN_rdata_o`/`respN_err_o` are valid this cycle and hold their value until the next RESP. Next state is IDLE.
- APB outputs outside SETUP/ACCESS: psel, penable, pwrite = 0; paddr and pwdata hold their last value.
- Holding registers are stable from SETUP through ACCESS, per the APB stability rule.
- Request fields are not required to stay stable after `ready`.
- Reset mid-transfer: the transfer is abandoned with no response to either port. The slave sees psel drop on the next cycle.

## Timing
- Reset values: state=IDLE, rr=0, all psel/penable/pwrite/ready/resp_valid/err = 0, paddr=0, pwdata=0, resp rdata=0.
- Zero-wait-state transfer: accept at cycle T, SETUP T+1, ACCESS T+2, `resp_valid` at T+3. The next accept can occur at T+4.
- Each slave wait cycle adds 1 cycle of latency.
- Timeout: ACCESS occupies exactly TIMEOUT cycles, then RESP.
- A `reqN_valid_i` deasserted before acceptance is legal and is dropped without side effect.
- A requester may reassert valid during its own RESP cycle; it is considered in the following IDLE cycle.
- Fairness under continuous contention: strict alternation, so no requester waits more than one transfer.

## Test plan
- Single read, zero wait: req0 read addr 0x000, slave returns 0x0001_0101 at pready=1 -> psel at T+1, penable at T+2, `resp0_valid_o` at T+3 with rdata=0x0001_0101, err=0; `resp1_valid_o` stays 0.
- Write with 2 wait states: req1 write addr 0x004 data 0xDEAD_BEEF -> pwrite=1, pwdata=0xDEAD_BEEF stable for 3 ACCESS cycles; `resp1_valid_o` at T+5, rdata=0, err=0.
- Contention after reset: both valid at cycle 0 -> req0 granted first, req1 granted at T+4. With both still valid, the next grant goes to req0 (alternation holds for 4 transfers).
- Slave error: req0 read with pslverr=1 and prdata=0x1234 -> `resp0_err_o`=1, rdata=0x1234.
- Timeout with TIMEOUT=4 and pready held 0: exactly 4 ACCESS cycles, then `resp0_valid_o`=1, err=1, rdata=0, psel=0 in RESP.
- Reset asserted during ACCESS -> next cycle psel=0, penable=0, state IDLE, no `resp_valid`, rr=0.
